pipelined_adder_nbit: RTL and testbench
=======================================

Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined, segmented ripple adder; successor to the fixed 32-bit adder built from hierarchical sub-adders.
- Splits the WIDTH-bit operands into SEG-bit segments. One segment is added per pipeline stage, and the carry is registered between stages.
- Valid/ready streaming interface, so it can sit on datapath streams at high clock rates.
- Used wherever a wide adder (64/128-bit) misses timing as a single combinational add.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SEG.
- SEG, 8, segment width added per stage; number of stages NSEG = WIDTH/SEG; SEG == WIDTH is legal (single stage).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A (unsigned/two's complement agnostic).
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  sum[WIDTH-1:0].
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance; this is a combinational path from out_ready and is permitted.
  - When advance = 0, every pipeline register, including the valid bits, holds its value.
- Stage k (k = 1..NSEG), on advance:
  - Registers valid_k = valid_{k-1}. Stage 0's valid is in_valid.
  - Computes {c_k, s_k} = A_seg[k-1] + B_seg[k-1] + c_{k-1}, as a (SEG+1)-bit result. c_0 = in_cin.
  - Forwards the not-yet-added upper segments of A and B, plus the already-computed lower sum segments.
- Segment addition uses exact unsigned (SEG+1)-bit arithmetic; no truncation except dropping the carry into the next stage's register.
- Output mapping:
  - out_sum = concatenation of s_NSEG..s_1.
  - out_cout = c_NSEG.
  - out_ovf = c_NSEG XOR (carry into bit WIDTH-1). The carry into bit WIDTH-1 is captured in the last stage.
- Latency: exactly NSEG cycles from input transfer to out_valid, with no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Ordering: results emerge strictly in acceptance order. No beat is dropped or duplicated under any stall pattern.
- Bubbles (valid = 0 stages) propagate with advance. The design does not collapse bubbles.
- Output stability: out_sum, out_cout and out_ovf stay stable while out_valid && !out_ready.
- Reset:
  - All valid bits = 0; out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight beats; nothing emerges afterwards from pre-reset inputs.
  - in_valid is ignored while rst = 1.
- Simultaneous input and output transfer in the same cycle is normal full-throughput operation.
- Boundaries:
  - All-ones + 1 ripples its carry across every stage: sum = 0, cout = 1.
  - With SEG == WIDTH, latency = 1.
- Elaboration: a WIDTH % SEG != 0 configuration is rejected at elaboration.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled with the operand beat.
  - When in_sub = 1, the block computes A + ~B + 1 (in_cin is ignored and carry-in is forced to 1).
  - out_cout = 1 means no borrow; out_ovf flags signed subtraction overflow.
  - Latency and handshake are unchanged.
- Undefined: no in_sub port; add-only behaviour as above.

Test Plan:
- WIDTH=32, SEG=8; a=0xFFFFFFFF, b=0x00000001, cin=0 → exactly 4 cycles later out_sum=0x00000000, out_cout=1, out_ovf=0.
- Back-to-back stream of 16 random beats with out_ready tied 1 → one result per cycle, in order, each matching the reference model {cout, sum} = a + b + cin; in_ready is constantly 1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1, cout=0. Also a=0x80000000, b=0x80000000 → sum=0, ovf=1, cout=1.
- Backpressure: stream 10 beats while out_ready toggles with a random 50% pattern → no loss or duplication, outputs held stable while stalled, in_ready = 0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid = 0 next cycle and all outputs zero; the next accepted beat (5+7) emerges 4 cycles after acceptance with sum=12.
- With PIPELINED_ADDER_SUB_EN: a=5, b=7, in_sub=1 → sum=0xFFFFFFFE, cout=0 (borrow). Then a=7, b=5, in_sub=1 → sum=2, cout=1. Repeat both with WIDTH=64, SEG=16 (latency 4) and WIDTH=SEG=32 (latency 1).

Source files
------------

// File: rtl/pipelined_adder_nbit.sv
// ============================================================================
// Module   : pipelined_adder_nbit
// Brief    : Segmented ripple adder, one SEG-bit segment per pipeline stage,
//            with a valid/ready stream interface and global stall.
//            Optional subtract mode: define PIPELINED_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder_nbit #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int c_NSEG = WIDTH / SEG;

    if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("pipelined_adder_nbit: WIDTH must be a positive multiple of SEG");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             r_ovf;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

`ifdef PIPELINED_ADDER_SUB_EN
    assign w_b0 = in_sub ? ~in_b : in_b;
    assign w_c0 = in_sub | in_cin;
`else
    assign w_b0 = in_b;
    assign w_c0 = in_cin;
`endif

    genvar i;
    for (i = 0; i < c_NSEG; i++) begin : g_stage
        // Operand bits still to be added when entering this stage.
        localparam int c_REM = WIDTH - i * SEG;

        logic [c_REM-1:0]     w_a;
        logic [c_REM-1:0]     w_b;
        logic                 w_c;
        logic                 w_v;
        logic [SEG:0]         w_add;
        logic                 r_v;
        logic                 r_c;
        logic [(i+1)*SEG-1:0] r_s;

        assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
            end else if (w_advance) begin
                r_v <= w_v;
                r_c <= w_add[SEG];
            end
        end

        if (i == 0) begin : g_first
            assign w_a = in_a;
            assign w_b = w_b0;
            assign w_c = w_c0;
            assign w_v = in_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s <= '0;
                end else if (w_advance) begin
                    r_s <= w_add[SEG-1:0];
                end
            end
        end else begin : g_next
            assign w_a = g_stage[i-1].g_fwd.r_a;
            assign w_b = g_stage[i-1].g_fwd.r_b;
            assign w_c = g_stage[i-1].r_c;
            assign w_v = g_stage[i-1].r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s <= '0;
                end else if (w_advance) begin
                    r_s <= {w_add[SEG-1:0], g_stage[i-1].r_s};
                end
            end
        end

        if (i < c_NSEG - 1) begin : g_fwd
            logic [c_REM-SEG-1:0] r_a;
            logic [c_REM-SEG-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a[c_REM-1:SEG];
                    r_b <= w_b[c_REM-1:SEG];
                end
            end
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= g_stage[c_NSEG-1].w_add[SEG]
                   ^ (g_stage[c_NSEG-1].w_a[SEG-1]
                   ^  g_stage[c_NSEG-1].w_b[SEG-1]
                   ^  g_stage[c_NSEG-1].w_add[SEG-1]);
        end
    end

    assign out_valid = g_stage[c_NSEG-1].r_v;
    assign out_sum   = g_stage[c_NSEG-1].r_s;
    assign out_cout  = g_stage[c_NSEG-1].r_c;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
// ============================================================================
// Module   : tb_pipelined_adder_nbit
// Brief    : Directed self-checking bench for pipelined_adder_nbit (32/8,
//            32/32 and 64/16 configurations); honours PIPELINED_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_cin, sub;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;

    logic        one_iv, one_ir, one_cin, one_sub, one_ov, one_cout, one_ovf;
    logic [31:0] one_a, one_b, one_sum;

    logic        wide_iv, wide_ir, wide_cin, wide_sub, wide_ov, wide_cout, wide_ovf;
    logic [63:0] wide_a, wide_b, wide_sum;

    int          vectors;
    int          errs;
    logic [33:0] q[$];
    logic [33:0] held;
    logic        held_v;

    always #5 clk = ~clk;

    pipelined_adder_nbit #(.WIDTH(32), .SEG(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_adder_nbit #(.WIDTH(32), .SEG(32)) u_one (
        .clk(clk), .rst(rst), .in_valid(one_iv), .in_ready(one_ir),
        .in_a(one_a), .in_b(one_b), .in_cin(one_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub(one_sub),
`endif
        .out_valid(one_ov), .out_ready(1'b1), .out_sum(one_sum),
        .out_cout(one_cout), .out_ovf(one_ovf)
    );

    pipelined_adder_nbit #(.WIDTH(64), .SEG(16)) u_wide (
        .clk(clk), .rst(rst), .in_valid(wide_iv), .in_ready(wide_ir),
        .in_a(wide_a), .in_b(wide_b), .in_cin(wide_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub(wide_sub),
`endif
        .out_valid(wide_ov), .out_ready(1'b1), .out_sum(wide_sum),
        .out_cout(wide_cout), .out_ovf(wide_ovf)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, sum}; overflow from operand/result sign bits.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] r;
        logic        ovf;
        bb  = s ? ~b : b;
        cc  = s ? 1'b1 : c;
        r   = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        ovf = (a[31] == bb[31]) && (r[31] != a[31]);
        return {r[32], ovf, r[31:0]};
    endfunction

    // One main-DUT clock with scoreboard, handshake and hold checks.
    task automatic step(output logic acc);
        logic        xin, xout;
        logic [33:0] obs;
        #1;
        xin  = in_valid && in_ready;
        xout = out_valid && out_ready;
        obs  = {out_cout, out_ovf, out_sum};
        chk({63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)}, "in_ready");
        if (held_v) chk({30'd0, obs}, {30'd0, held}, "hold");
        held_v = out_valid && !out_ready;
        held   = obs;
        if (xout) begin
            if (q.size() == 0) chk({63'd0, out_valid}, 64'd0, "extra_beat");
            else               chk({30'd0, obs}, {30'd0, q.pop_front()}, "stream");
        end
        if (xin) q.push_back(model(in_a, in_b, in_cin, sub));
        acc = xin;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ov(input int u);
        return (u == 0) ? out_valid : (u == 1) ? one_ov : wide_ov;
    endfunction

    // Single directed beat into unit u (0 main, 1 32/32, 2 64/16) on an empty pipe.
    task automatic dir(input int u, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic s, input logic [63:0] es,
                       input logic ec, input logic eo, input int elat, input string tag);
        int          lat;
        logic [63:0] rs;
        logic        rc, ro;
        case (u)
            0:       begin in_a = a[31:0]; in_b = b[31:0]; in_cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1; end
            1:       begin one_a = a[31:0]; one_b = b[31:0]; one_cin = c; one_sub = s; one_iv = 1'b1; end
            default: begin wide_a = a; wide_b = b; wide_cin = c; wide_sub = s; wide_iv = 1'b1; end
        endcase
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; one_iv = 1'b0; wide_iv = 1'b0;
        lat = 1;
        while (!ov(u) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        case (u)
            0:       begin rs = {32'd0, out_sum};  rc = out_cout;  ro = out_ovf;  end
            1:       begin rs = {32'd0, one_sum};  rc = one_cout;  ro = one_ovf;  end
            default: begin rs = wide_sum;          rc = wide_cout; ro = wide_ovf; end
        endcase
        chk(64'(lat), 64'(elat), {tag, "_lat"});
        chk(rs, es, {tag, "_sum"});
        chk({62'd0, rc, ro}, {62'd0, ec, eo}, {tag, "_cout_ovf"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   guard;
        vectors = 0; errs = 0; held_v = 1'b0; held = '0;
        in_a = '0; in_b = '0; in_cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        one_a = '0; one_b = '0; one_cin = 1'b0; one_sub = 1'b0; one_iv = 1'b0;
        wide_a = '0; wide_b = '0; wide_cin = 1'b0; wide_sub = 1'b0; wide_iv = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1;   // must be ignored under reset
        repeat (3) @(posedge clk);
        #1;
        chk({29'd0, out_valid, out_cout, out_ovf, out_sum}, 64'd0, "reset_outputs");
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk({63'd0, in_ready}, 64'd1, "reset_in_ready");
        @(posedge clk);
        #1;
        repeat (6) step(acc);

        // Directed boundaries on the 32/8 pipeline.
        dir(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 4, "ripple");
        dir(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 4, "ovf_pos");
        dir(0, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 4, "ovf_neg");
        dir(0, 64'h1234_5678, 64'h1111_1111, 1'b1, 1'b0, 64'h2345_678A, 1'b0, 1'b0, 4, "cin");

        // Full-throughput random stream.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1)); sub = 1'b0;
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        repeat (6) step(acc);
        chk(64'(q.size()), 64'd0, "stream_drain");

        // Random backpressure.
        for (int k = 0; k < 10; k++) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1)); sub = 1'b0;
            in_valid = 1'b1;
            guard = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                step(acc);
                guard++;
            end while (!acc && guard < 100);
        end
        in_valid = 1'b0;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            step(acc);
            guard++;
        end
        chk(64'(q.size()), 64'd0, "bp_drain");
        out_ready = 1'b1;

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            in_a = 32'(k + 100); in_b = 32'(k); in_cin = 1'b0; in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({29'd0, out_valid, out_cout, out_ovf, out_sum}, 64'd0, "midrst_outputs");
        q.delete();
        held_v = 1'b0;
        repeat (6) step(acc);
        dir(0, 64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0, 4, "post_rst");

        // Other configurations.
        dir(1, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1, "one_ripple");
        dir(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 4, "wide_ripple");
        dir(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4, "wide_ovf");

`ifdef PIPELINED_ADDER_SUB_EN
        dir(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 4, "sub_borrow");
        dir(0, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 4, "sub_ok");
        dir(0, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 4, "sub_ovf");
        dir(2, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4, "wide_sub_borrow");
        dir(2, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 4, "wide_sub_ok");
        dir(1, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1, "one_sub_borrow");
        dir(1, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1, "one_sub_ok");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
